// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, half-bit start check, LSB-first data, stop-bit framing check.
// Emits a one-cycle byte_valid with the received byte, or a one-cycle frame_err.
module servant_uart_rx #(
  parameter int CLK_DIV = 139
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(CLK_DIV);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    state;
  logic          rx_s1, rx_s2;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign rx_byte = shreg;

  // Start detection costs one cycle, so the half-bit timer is loaded two short.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= RX_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= i_rx;
      rx_s2      <= rx_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s2) begin
            state <= RX_START;
            timer <= TW'(CLK_DIV / 2 - 2);
          end
        end
        RX_START: begin
          if (timer == '0) begin
            if (rx_s2) begin
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              timer   <= TW'(CLK_DIV - 1);
              bit_cnt <= '0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        RX_DATA: begin
          if (timer == '0) begin
            shreg <= {rx_s2, shreg[7:1]};
            timer <= TW'(CLK_DIV - 1);
            if (bit_cnt == 3'd7) state <= RX_STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          if (timer == '0) begin
            state <= RX_IDLE;
            if (rx_s2) byte_valid <= 1'b1;
            else frame_err <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/servant_uart_loader.sv
// Serial boot loader: receives a length-prefixed image over UART and writes it to RAM as a
// Wishbone initiator, holding the CPU in reset until the whole image is written.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_HDR   | collecting the 4-byte little-endian word count N
// ST_DATA  | collecting 4 bytes of the next data word
// ST_WRITE | Wishbone write in flight, waiting for ack
// ST_DONE  | image written, CPU released, UART ignored
// ST_ERR   | framing error or overflow, CPU held, exit only by reset
module servant_uart_loader #(
  parameter int          CLK_DIV = 139,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  output logic        o_cpu_rst,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [2:0] ST_HDR   = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic        byte_valid, frame_err;
  logic [7:0]  rx_byte;
  logic [2:0]  state;
  logic [1:0]  byte_cnt;
  logic [31:0] n_word, idx, shift_q;
  logic [31:0] n_next, word_next, idx_inc;

  servant_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx       (i_rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  assign n_next    = {rx_byte, n_word[31:8]};
  assign word_next = {rx_byte, shift_q[31:8]};
  assign idx_inc   = idx + 32'd1;
  assign o_wb_we   = o_wb_cyc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_HDR;
      byte_cnt  <= '0;
      n_word    <= '0;
      idx       <= '0;
      shift_q   <= '0;
      o_wb_adr  <= '0;
      o_wb_dat  <= '0;
      o_wb_sel  <= '0;
      o_wb_cyc  <= 1'b0;
      o_cpu_rst <= 1'b1;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      case (state)
        ST_HDR: begin
          if (frame_err) begin
            state <= ST_ERR;
            o_err <= 1'b1;
          end else if (byte_valid) begin
            n_word   <= n_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (n_next == '0) begin
                state     <= ST_DONE;
                o_done    <= 1'b1;
                o_cpu_rst <= 1'b0;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (frame_err) begin
            state <= ST_ERR;
            o_err <= 1'b1;
          end else if (byte_valid) begin
            shift_q  <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= ST_WRITE;
              o_wb_dat <= word_next;
              o_wb_adr <= BASE + {idx[29:0], 2'b00};
              o_wb_sel <= 4'hF;
              o_wb_cyc <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // A new byte arriving before the ack means the sender outran the bus: abandon the cycle.
          if (frame_err || byte_valid) begin
            state    <= ST_ERR;
            o_err    <= 1'b1;
            o_wb_cyc <= 1'b0;
            o_wb_sel <= '0;
          end else if (i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_sel <= '0;
            idx      <= idx_inc;
            if (idx_inc == n_word) begin
              state     <= ST_DONE;
              o_done    <= 1'b1;
              o_cpu_rst <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DONE: ;
        ST_ERR: ;
        default: state <= ST_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_uart_loader.sv
// Directed bench for servant_uart_loader: drives UART frames, models a Wishbone responder,
// and checks writes, completion timing, errors and reset behaviour with immediate assertions.
module tb_servant_uart_loader;

  localparam int C = 16;
  localparam int BYTE_LAT = 2 + C / 2 + 9 * C;

  logic        clk, rst_n, rx, ack;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, cpu_rst, done, err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int last_start = 0;
  int done_cycle = 0;
  logic done_q = 1'b0;

  int ack_delay = 0;
  logic ack_en = 1'b1;
  int wr_count = 0;
  int wait_cnt = 0;
  int stable_bad = 0;
  int drop_bad = 0;
  logic [31:0] wr_adr [0:15];
  logic [31:0] wr_dat [0:15];
  int          wr_cycle [0:15];
  logic        ack_done [0:15];

  servant_uart_loader #(.CLK_DIV(C), .BASE(32'h0000_0000)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx      (rx),
    .o_wb_adr  (adr),
    .o_wb_dat  (dat),
    .o_wb_sel  (sel),
    .o_wb_we   (we),
    .o_wb_cyc  (cyc),
    .i_wb_ack  (ack),
    .o_cpu_rst (cpu_rst),
    .o_done    (done),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !done_q) done_cycle = cyc_cnt;
      done_q = (done === 1'b1);
    end
  end

  // Wishbone responder: records each write, acks after ack_delay cycles, checks hold and drop.
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack) begin
        ack = 1'b0;
        wait_cnt = 0;
        if (cyc !== 1'b0) drop_bad++;
        if (wr_count > 0 && wr_count <= 16) ack_done[wr_count-1] = done;
      end else if (cyc === 1'b1 && ack_en) begin
        if (wait_cnt == 0) begin
          if (wr_count < 16) begin
            wr_adr[wr_count]   = adr;
            wr_dat[wr_count]   = dat;
            wr_cycle[wr_count] = cyc_cnt;
          end
          wr_count++;
        end else if (wr_count <= 16 && (adr !== wr_adr[wr_count-1] || dat !== wr_dat[wr_count-1]
                     || sel !== 4'hF || we !== 1'b1)) begin
          stable_bad++;
        end
        if (wait_cnt >= ack_delay) ack = 1'b1;
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    last_start = cyc_cnt;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b, s;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_adr", adr, 32'h0);
    chk("rst_dat", dat, 32'h0);
    chk("rst_sel", {28'h0, sel}, 32'h0);
    chk("rst_we", {31'h0, we}, 32'h0);
    chk("rst_cyc", {31'h0, cyc}, 32'h0);
    chk("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=2 image, quick acks
    ack_delay = 3;
    b = wr_count;
    send_word(32'd2);
    chk("n2_cpu_rst_hdr", {31'h0, cpu_rst}, 32'h1);
    chk("n2_done_hdr", {31'h0, done}, 32'h0);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    s = last_start;
    send_word(32'hDEADBEEF);
    repeat (20) @(negedge clk);
    chk("n2_count", wr_count - b, 32'd2);
    chk("n2_adr0", wr_adr[b], 32'h0000_0000);
    chk("n2_dat0", wr_dat[b], 32'h1234_5678);
    chk("n2_adr1", wr_adr[b+1], 32'h0000_0004);
    chk("n2_dat1", wr_dat[b+1], 32'hDEAD_BEEF);
    chk("n2_cyc_latency", wr_cycle[b] - s, BYTE_LAT + 1);
    chk("n2_done_at_ack0", {31'h0, ack_done[b]}, 32'h0);
    chk("n2_done_at_ack1", {31'h0, ack_done[b+1]}, 32'h1);
    chk("n2_done", {31'h0, done}, 32'h1);
    chk("n2_cpu_rst", {31'h0, cpu_rst}, 32'h0);
    chk("n2_err", {31'h0, err}, 32'h0);

    // N=0: done one cycle after the 4th header byte, no bus cycle
    do_reset();
    chk("rst2_done", {31'h0, done}, 32'h0);
    b = wr_count;
    send_word(32'd0);
    repeat (5) @(negedge clk);
    chk("n0_count", wr_count - b, 32'd0);
    chk("n0_done", {31'h0, done}, 32'h1);
    chk("n0_cpu_rst", {31'h0, cpu_rst}, 32'h0);
    chk("n0_done_latency", done_cycle - last_start, BYTE_LAT + 1);

    // 50-cycle ack delay
    do_reset();
    ack_delay = 50;
    b = wr_count;
    send_word(32'd1);
    send_word(32'h1122_3344);
    repeat (70) @(negedge clk);
    chk("dly_count", wr_count - b, 32'd1);
    chk("dly_adr", wr_adr[b], 32'h0);
    chk("dly_dat", wr_dat[b], 32'h1122_3344);
    chk("dly_done", {31'h0, done}, 32'h1);
    chk("dly_cyc", {31'h0, cyc}, 32'h0);

    // stop bit low on data byte 3
    do_reset();
    ack_delay = 2;
    b = wr_count;
    send_word(32'd2);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    send_word(32'h0403_0201);
    repeat (10) @(negedge clk);
    chk("fe_err", {31'h0, err}, 32'h1);
    chk("fe_count", wr_count - b, 32'd0);
    chk("fe_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    chk("fe_done", {31'h0, done}, 32'h0);
    chk("fe_cyc", {31'h0, cyc}, 32'h0);

    // glitch shorter than half a bit
    do_reset();
    chk("rst_err_clear", {31'h0, err}, 32'h0);
    @(negedge clk);
    rx = 1'b0;
    repeat (C / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("gl_err", {31'h0, err}, 32'h0);
    b = wr_count;
    send_word(32'd1);
    send_word(32'h0BAD_F00D);
    repeat (10) @(negedge clk);
    chk("gl_count", wr_count - b, 32'd1);
    chk("gl_dat", wr_dat[b], 32'h0BAD_F00D);
    chk("gl_adr", wr_adr[b], 32'h0);
    chk("gl_done", {31'h0, done}, 32'h1);

    // reset while in WRITE
    do_reset();
    ack_en = 1'b0;
    send_word(32'd1);
    send_word(32'hCAFE_0001);
    repeat (5) @(negedge clk);
    chk("rw_cyc_pending", {31'h0, cyc}, 32'h1);
    chk("rw_dat_pending", dat, 32'hCAFE_0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rw_cyc_async", {31'h0, cyc}, 32'h0);
    chk("rw_sel_async", {28'h0, sel}, 32'h0);
    chk("rw_dat_async", dat, 32'h0);
    chk("rw_cpu_rst_async", {31'h0, cpu_rst}, 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    b = wr_count;
    send_word(32'd1);
    send_word(32'h3CC3_A55A);
    repeat (10) @(negedge clk);
    chk("rw_count", wr_count - b, 32'd1);
    chk("rw_adr", wr_adr[b], 32'h0);
    chk("rw_dat", wr_dat[b], 32'h3CC3_A55A);
    chk("rw_done", {31'h0, done}, 32'h1);

    // byte arriving during WRITE
    do_reset();
    ack_en = 1'b0;
    send_word(32'd1);
    send_word(32'h5555_AAAA);
    repeat (5) @(negedge clk);
    chk("ov_cyc_pending", {31'h0, cyc}, 32'h1);
    send_byte(8'h55, 1'b1);
    chk("ov_err", {31'h0, err}, 32'h1);
    chk("ov_cyc", {31'h0, cyc}, 32'h0);
    chk("ov_cpu_rst", {31'h0, cpu_rst}, 32'h1);
    chk("ov_done", {31'h0, done}, 32'h0);
    ack_en = 1'b1;

    chk("hold_stable", stable_bad, 32'd0);
    chk("drop_on_ack", drop_bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/servant_uart_loader.md
# servant_uart_loader

Serial boot loader acting as a Wishbone initiator on the servant memory bus. It receives a length-prefixed program image over an 8N1 UART line and writes it word by word into RAM starting at a fixed base address. It holds the CPU in reset until the image is fully written. It is the write-side counterpart to the CPU instruction fetch: it fills the memory that the CPU later reads.

## Interface
Parameters:
- CLK_DIV, 139: clock cycles per UART bit (16 MHz / 115200); must be ≥ 8.
- BASE, 32'h0000_0000: byte address of the first written word.

Ports:
- i_clk, in, 1: system clock; all logic on rising edge.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_rx, in, 1: UART receive line, idle high, asynchronous to i_clk.
- o_wb_adr, out, 32: write address, word aligned.
- o_wb_dat, out, 32: write data, little-endian assembled word.
- o_wb_sel, out, 4: byte enables, always 4'b1111 when o_wb_cyc is high.
- o_wb_we, out, 1: write enable, equal to o_wb_cyc.
- o_wb_cyc, out, 1: cycle request; held until acknowledged.
- i_wb_ack, in, 1: one-cycle acknowledge from the responder.
- o_cpu_rst, out, 1: active-high CPU reset; high until load completes.
- o_done, out, 1: image fully written; sticky.
- o_err, out, 1: framing or overflow error; sticky.

## Operation
- Reset values: o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_wb_we=0, o_wb_cyc=0, o_cpu_rst=1, o_done=0, o_err=0. The state is HDR and all counters are 0.
- Receiver: i_rx passes through a 2-flop synchronizer. A falling edge in idle starts a start-bit check at CLK_DIV/2 (integer division).
  - If the line is high at that check, the start is false: return to idle with no byte and no error.
  - Otherwise, 8 data bits are sampled LSB first, one every CLK_DIV cycles. The stop bit is sampled CLK_DIV cycles later.
  - Stop bit = 1: a one-cycle byte_valid pulse with the byte. Stop bit = 0: framing error.
- Frame format: 4 header bytes, little-endian 32-bit word count N, followed by 4·N data bytes. Each group of 4 data bytes is little-endian (first byte goes to [7:0]).
- States:
  - HDR: collect 4 bytes into N. After the 4th byte, go to DONE if N=0, otherwise go to DATA.
  - DATA: collect bytes into a shift register. After the 4th byte, latch the word and go to WRITE.
  - WRITE: hold cyc/we/sel/adr/dat until i_wb_ack. On ack, drop cyc, increment the word index, and go to DONE if index = N, otherwise go to DATA.
  - DONE: o_done=1 and o_cpu_rst=0. Ignore all further UART traffic.
  - ERR: o_err=1, o_cpu_rst stays 1, o_wb_cyc=0. Only reset exits ERR.
- Address: o_wb_adr = BASE + 4·index, modulo 2^32; it wraps silently.
- Errors that send the block to ERR:
  - A framing error in any state other than DONE.
  - A byte_valid while in WRITE (overflow). The in-flight cycle is abandoned: cyc is dropped the same cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). A partial image is discarded and no Wishbone cycle is left open.

## Timing
- Byte latency: byte_valid fires 2 (synchronizer) + CLK_DIV/2 + 9·CLK_DIV cycles after the falling edge of the start bit reaches i_rx.
- Wishbone request: o_wb_cyc rises on the clock edge after the 4th data byte's byte_valid. That is 1 cycle of latency, with registered outputs.
- Wishbone completion:
  - Ack seen at edge k means o_wb_cyc is low from edge k.
  - Back-to-back acks are impossible, because the next request needs 4 more bytes.
  - Ack while cyc is low is ignored.
- Completion: o_done and the fall of o_cpu_rst happen on the edge that samples the final ack (or the 4th header byte when N=0). They are simultaneous and registered.
- A framing error and an ack in the same cycle: the error wins, and the state goes to ERR with the word counted as not written.

## Structure
- Sub-module servant_uart_rx (synchronizer, bit timer, bit counter, framing check). Outputs: byte_valid, byte[7:0], frame_err. Parameter: CLK_DIV.
- The top holds the loader FSM, the 32-bit N register, the word index counter, the 32-bit shift register and the Wishbone output registers.
- No shared package. State encodings are local parameters of the loader; CLK_DIV and BASE are the only shared constants and enter as parameters.

## Test plan
- N=2, bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE, BASE=0 -> writes 0x12345678@0x0 then 0xDEADBEEF@0x4. o_done=1 and o_cpu_rst=0 after the 2nd ack.
- Header N=0 -> no Wishbone cycle. o_done=1 and o_cpu_rst=0 one cycle after the 4th header byte.
- Responder delays ack by 50 cycles -> cyc, adr and dat stay stable for all 50 cycles, then cyc drops on the ack edge.
- Stop bit forced low on data byte 3 -> o_err=1, no further writes, o_cpu_rst stays 1. Later valid bytes are ignored.
- Glitch: i_rx low for CLK_DIV/4 cycles -> no byte, no error. Next real frame is received correctly.
- i_rst_n asserted while in WRITE -> o_wb_cyc=0 asynchronously. After release, a fresh N=1 image loads at BASE.
